// File: rtl/pellet_tracker_if.sv
// Game-side bundle for the pellet tracker: Pac-Man position in, renderer tile
// query in, pellet/score status out.
interface pellet_tracker_if;
    logic [9:0]  pm_xpos;
    logic [9:0]  pm_ypos;
    logic [4:0]  rd_col;
    logic [4:0]  rd_row;
    logic        rd_pellet;
    logic        rd_power;
    logic        eat_pulse;
    logic        power_pulse;
    logic [15:0] score;
    logic [9:0]  pellets_left;
    logic        level_clear;

    modport master (
        output pm_xpos, pm_ypos, rd_col, rd_row,
        input  rd_pellet, rd_power, eat_pulse, power_pulse, score, pellets_left, level_clear
    );

    modport slave (
        input  pm_xpos, pm_ypos, rd_col, rd_row,
        output rd_pellet, rd_power, eat_pulse, power_pulse, score, pellets_left, level_clear
    );
endinterface

// File: rtl/pellet_tracker.sv
// Maps Pac-Man's pixel position onto a maze tile, eats pellets on tile entry,
// keeps score / remaining count and serves a registered tile read port.
module pellet_tracker #(
    parameter int                   COLS        = 28,
    parameter int                   ROWS        = 31,
    parameter int                   TILE_SHIFT  = 3,
    parameter logic [9:0]           X_ORIGIN    = 10'd208,
    parameter logic [9:0]           Y_ORIGIN    = 10'd10,
    parameter logic [ROWS*COLS-1:0] PELLET_INIT = '1,
    parameter logic [ROWS*COLS-1:0] POWER_MASK  = '0,
    parameter logic [15:0]          PTS_PELLET  = 16'd10,
    parameter logic [15:0]          PTS_POWER   = 16'd50
) (
    input  logic            clk,
    input  logic            rst,
    pellet_tracker_if.slave bus
);
    localparam int NT    = ROWS * COLS;
    localparam int IDX_W = $clog2(NT);

    function automatic logic [9:0] popcount(input logic [NT-1:0] v);
        logic [9:0] n;
        n = '0;
        for (int i = 0; i < NT; i++) n = n + 10'(v[i]);
        return n;
    endfunction

    localparam logic [9:0] INIT_LEFT = popcount(PELLET_INIT);

    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;

    state_t           state, state_nx;
    logic [NT-1:0]    bitmap;
    logic             tile_vld_q;
    logic [IDX_W-1:0] tile_q;
    logic             last_vld;
    logic [IDX_W-1:0] last_tile;
    logic [IDX_W-1:0] cur_tile;
    logic             hit, pw;
    logic [15:0]      score_q;
    logic [9:0]       left_q;
    logic             eat_q, power_q, clear_q;
    logic             rd_pellet_q, rd_power_q;

    // Pixel -> tile decode; subtraction wraps when left/above the origin,
    // which the explicit origin compares reject.
    logic [9:0]       dx, dy, col_px, row_px;
    logic             tile_ok;
    logic [IDX_W-1:0] tile_idx;

    assign dx       = bus.pm_xpos - X_ORIGIN;
    assign dy       = bus.pm_ypos - Y_ORIGIN;
    assign col_px   = dx >> TILE_SHIFT;
    assign row_px   = dy >> TILE_SHIFT;
    assign tile_ok  = (bus.pm_xpos >= X_ORIGIN) && (bus.pm_ypos >= Y_ORIGIN) &&
                      (int'(col_px) < COLS) && (int'(row_px) < ROWS);
    assign tile_idx = IDX_W'(int'(row_px) * COLS + int'(col_px));

    logic             rd_ok;
    logic [IDX_W-1:0] rd_idx;

    assign rd_ok  = (int'(bus.rd_col) < COLS) && (int'(bus.rd_row) < ROWS);
    assign rd_idx = IDX_W'(int'(bus.rd_row) * COLS + int'(bus.rd_col));

    logic new_tile;
    assign new_tile = !clear_q && tile_vld_q && (!last_vld || tile_q != last_tile);

    logic [16:0] sum;
    assign sum = {1'b0, score_q} + {1'b0, (pw ? PTS_POWER : PTS_PELLET)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (new_tile) state_nx = LOOKUP;
            LOOKUP:  state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap      <= PELLET_INIT;
            tile_vld_q  <= 1'b0;
            tile_q      <= '0;
            last_vld    <= 1'b0;
            last_tile   <= '0;
            cur_tile    <= '0;
            hit         <= 1'b0;
            pw          <= 1'b0;
            score_q     <= '0;
            left_q      <= INIT_LEFT;
            eat_q       <= 1'b0;
            power_q     <= 1'b0;
            clear_q     <= (INIT_LEFT == 10'd0);
            rd_pellet_q <= 1'b0;
            rd_power_q  <= 1'b0;
        end else begin
            tile_vld_q  <= tile_ok;
            tile_q      <= tile_idx;
            eat_q       <= 1'b0;
            power_q     <= 1'b0;
            clear_q     <= (left_q == 10'd0);
            // Read sees the bitmap before this edge's clear (read-before-write).
            rd_pellet_q <= rd_ok && bitmap[rd_idx];
            rd_power_q  <= rd_ok && bitmap[rd_idx] && POWER_MASK[rd_idx];
            case (state)
                IDLE: begin
                    if (new_tile) begin
                        cur_tile  <= tile_q;
                        last_tile <= tile_q;
                        last_vld  <= 1'b1;
                    end
                end
                LOOKUP: begin
                    hit <= bitmap[cur_tile];
                    pw  <= POWER_MASK[cur_tile];
                end
                UPDATE: begin
                    if (hit) begin
                        bitmap[cur_tile] <= 1'b0;
                        left_q           <= left_q - 10'd1;
                        score_q          <= sum[16] ? 16'hFFFF : sum[15:0];
                        eat_q            <= 1'b1;
                        power_q          <= pw;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_pellet    = rd_pellet_q;
    assign bus.rd_power     = rd_power_q;
    assign bus.eat_pulse    = eat_q;
    assign bus.power_pulse  = power_q;
    assign bus.score        = score_q;
    assign bus.pellets_left = left_q;
    assign bus.level_clear  = clear_q;
endmodule
